// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: default sizes, tag type,
// the broadcast record seen by consumers, and the round-robin pointer step.
package cdb_arbiter_pkg;

  localparam int N_SRC_DEF  = 7;
  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;

  // Tag 0 means "no producer / operand ready"; sources use 1..N_SRC.
  typedef logic [TAG_W_DEF-1:0] tag_t;

  // One broadcast as seen by the register file and reservation stations.
  typedef struct packed {
    logic                  valid;
    tag_t                  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_bus_t;

  // Pointer position after tag w wins: one past it, wrapping n back to 1.
  function automatic int unsigned next_ptr(input int unsigned w, input int unsigned n);
    if (w >= n) begin
      return 32'd1;
    end else begin
      return w + 32'd1;
    end
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of result-source handshakes and the broadcast side of the CDB.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [N_SRC-1:0]             src_valid;
  logic [N_SRC-1:0][DATA_W-1:0] src_data;
  logic [N_SRC-1:0]             src_ready;
  logic                         cdb_valid;
  logic [TAG_W-1:0]             cdb_tag;
  logic [DATA_W-1:0]            cdb_data;
  logic [N_SRC-1:0]             pending;

  // Result producers and broadcast consumers.
  modport master (
    output src_valid, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, pending
  );

  // The arbiter itself.
  modport slave (
    input  src_valid, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, pending
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending source at or after rr_ptr,
// wrapping N_SRC back to 1. Produces a one-hot grant and the winning tag.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [TAG_W-1:0] rr_ptr,
  output logic [N_SRC-1:0] grant,
  output logic [TAG_W-1:0] win_tag,
  output logic             win_valid
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [IDX_W-1:0] idx_s;

  // Scan sources starting at the pointer and stop at the first one holding a result.
  always_comb begin
    grant     = '0;
    win_tag   = '0;
    win_valid = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx_s = IDX_W'((32'(rr_ptr) + 32'(N_SRC) - 32'd1 + 32'(k)) % 32'(N_SRC));
      if (!win_valid && pending[idx_s]) begin
        grant[idx_s] = 1'b1;
        win_tag      = TAG_W'(idx_s) + TAG_W'(1);
        win_valid    = 1'b1;
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold register per result source, round-robin
// selection of one held result per cycle, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          CLOCK_50,
  input  logic          RSTN_N,
  cdb_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  pending_r;
  logic [DATA_W-1:0] hold_r [N_SRC];
  logic [TAG_W-1:0]  rr_ptr_r;
  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_data_r;

  logic [N_SRC-1:0]  grant_s;
  logic [TAG_W-1:0]  win_tag_s;
  logic              win_valid_s;
  logic [N_SRC-1:0]  ready_s;
  logic [N_SRC-1:0]  accept_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [DATA_W-1:0] win_data_s;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .TAG_W (TAG_W)
  ) u_rr (
    .pending   (pending_r),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .win_tag   (win_tag_s),
    .win_valid (win_valid_s)
  );

  // A source may hand over a result when its slot is empty or being drained this cycle.
  always_comb begin
    ready_s  = ~pending_r | grant_s;
    accept_s = bus.src_valid & ready_s;
  end

  // Fetch the held value of the winning source for broadcast.
  always_comb begin
    win_idx_s = IDX_W'(win_tag_s - TAG_W'(1));
    if (win_valid_s) begin
      win_data_s = hold_r[win_idx_s];
    end else begin
      win_data_s = '0;
    end
  end

  // Occupancy: a reload wins over a drain, so grant+reload keeps the slot full.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      pending_r <= '0;
    end else begin
      pending_r <= accept_s | (pending_r & ~grant_s);
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_hold
    // Capture a source's result whenever it is accepted.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
      if (!RSTN_N) begin
        hold_r[i] <= '0;
      end else if (accept_s[i]) begin
        hold_r[i] <= bus.src_data[i];
      end else begin
        hold_r[i] <= hold_r[i];
      end
    end
  end

  // Broadcast the winner and advance the pointer past it; idle cycles drive zeros.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
      rr_ptr_r    <= TAG_W'(1);
    end else if (win_valid_s) begin
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= win_tag_s;
      cdb_data_r  <= win_data_s;
      rr_ptr_r    <= TAG_W'(next_ptr(32'(win_tag_s), N_SRC));
    end else begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

  assign bus.src_ready = ready_s;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_data  = cdb_data_r;
  assign bus.pending   = pending_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter plus hand-written sequences
// for asynchronous reset mid-run and sustained full load.
module tb_cdb_arbiter;

  typedef logic [6:0][31:0] darr_t;

  typedef struct packed {
    logic [6:0]  v;
    darr_t       d;
    logic        ecv;
    logic [2:0]  etag;
    logic [31:0] edata;
    logic [6:0]  epend;
    logic [6:0]  erdy;
  } vec_t;

  logic CLOCK_50;
  logic RSTN_N;
  int   checks;
  int   errors;
  vec_t vt[$];

  cdb_arbiter_if #(.N_SRC(7), .TAG_W(3), .DATA_W(32)) bus ();

  cdb_arbiter #(.N_SRC(7), .TAG_W(3), .DATA_W(32)) dut (
    .CLOCK_50 (CLOCK_50),
    .RSTN_N   (RSTN_N),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic darr_t d1(input logic [2:0] t, input logic [31:0] val);
    darr_t r;
    r = '0;
    r[t - 3'd1] = val;
    return r;
  endfunction

  function automatic darr_t dall();
    darr_t r;
    r = '0;
    for (int t = 1; t <= 7; t++) r[3'(t - 1)] = 32'(t * 256);
    return r;
  endfunction

  task automatic add(input logic [6:0] v, input darr_t d, input logic ecv, input logic [2:0] etag,
                     input logic [31:0] edata, input logic [6:0] epend, input logic [6:0] erdy);
    vec_t r;
    r.v = v; r.d = d; r.ecv = ecv; r.etag = etag; r.edata = edata; r.epend = epend; r.erdy = erdy;
    vt.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_out(input string tg, input logic cv, input logic [2:0] t, input logic [31:0] d,
                         input logic [6:0] p, input logic [6:0] r);
    chk({tg, " cdb_valid"}, 32'(bus.cdb_valid), 32'(cv));
    chk({tg, " cdb_tag"},   32'(bus.cdb_tag),   32'(t));
    chk({tg, " cdb_data"},  bus.cdb_data,       d);
    chk({tg, " pending"},   32'(bus.pending),   32'(p));
    chk({tg, " src_ready"}, 32'(bus.src_ready), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] et;
    logic [2:0] en;
    checks = 0;
    errors = 0;
    RSTN_N = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;

    // Collision, pointer at 1: tag1 then tag5, src5 not ready while tag1 is granted.
    add(7'h00, '0, 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    add(7'h11, d1(3'd1, 32'hA) | d1(3'd5, 32'hB), 1'b0, 3'd0, 32'h0, 7'h11, 7'h6F);
    add(7'h00, '0, 1'b1, 3'd1, 32'hA, 7'h10, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd5, 32'hB, 7'h00, 7'h7F);
    add(7'h00, '0, 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    // Single uncontested source: one cycle of latency, then idle.
    add(7'h04, d1(3'd3, 32'h10), 1'b0, 3'd0, 32'h0, 7'h04, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd3, 32'h10, 7'h00, 7'h7F);
    add(7'h00, '0, 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    // Back-to-back stream from src2: grant and reload on the same edge.
    add(7'h02, d1(3'd2, 32'h1), 1'b0, 3'd0, 32'h0, 7'h02, 7'h7F);
    add(7'h02, d1(3'd2, 32'h2), 1'b1, 3'd2, 32'h1, 7'h02, 7'h7F);
    add(7'h02, d1(3'd2, 32'h3), 1'b1, 3'd2, 32'h2, 7'h02, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd2, 32'h3, 7'h00, 7'h7F);
    add(7'h00, '0, 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    // Move pointer to 7 via src6, then wrap: tag7 before tag1, pointer ends at 2.
    add(7'h20, d1(3'd6, 32'h66), 1'b0, 3'd0, 32'h0, 7'h20, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd6, 32'h66, 7'h00, 7'h7F);
    add(7'h41, d1(3'd7, 32'h77) | d1(3'd1, 32'h11), 1'b0, 3'd0, 32'h0, 7'h41, 7'h7E);
    add(7'h00, '0, 1'b1, 3'd7, 32'h77, 7'h01, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd1, 32'h11, 7'h00, 7'h7F);
    add(7'h06, d1(3'd2, 32'h22) | d1(3'd3, 32'h33), 1'b0, 3'd0, 32'h0, 7'h06, 7'h7B);
    add(7'h00, '0, 1'b1, 3'd2, 32'h22, 7'h04, 7'h7F);
    add(7'h00, '0, 1'b1, 3'd3, 32'h33, 7'h00, 7'h7F);

    #5;
    chk_out("reset", 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    #20;
    RSTN_N = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      bus.src_valid = vt[i].v;
      bus.src_data  = vt[i].d;
      step();
      chk_out($sformatf("vec%0d", i), vt[i].ecv, vt[i].etag, vt[i].edata, vt[i].epend, vt[i].erdy);
    end

    // Reset mid-run: pointer is at 4 here.
    bus.src_valid = 7'h0F;
    bus.src_data  = dall();
    step();
    chk("mid load pending", 32'(bus.pending), 32'h0F);
    bus.src_valid = 7'h10;
    step();
    chk("mid cdb_valid", 32'(bus.cdb_valid), 32'h1);
    chk("mid cdb_tag", 32'(bus.cdb_tag), 32'h4);
    chk("mid cdb_data", bus.cdb_data, 32'h400);
    chk("mid pending", 32'(bus.pending), 32'h17);
    bus.src_valid = 7'h00;
    #5;
    RSTN_N = 1'b0;
    #1;
    chk_out("async rst", 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    step();
    chk_out("in rst", 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    #4;
    RSTN_N = 1'b1;
    chk("after release src_ready", 32'(bus.src_ready), 32'h7F);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("post rst%0d", i), 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);
    end

    // Full load from a fresh pointer: tags 1..7 in order, twice around.
    bus.src_valid = 7'h7F;
    bus.src_data  = dall();
    step();
    chk_out("full fill", 1'b0, 3'd0, 32'h0, 7'h7F, 7'h01);
    for (int k = 0; k < 14; k++) begin
      et = 3'((k % 7) + 1);
      en = 3'(((k + 1) % 7) + 1);
      step();
      chk_out($sformatf("full%0d", k), 1'b1, et, 32'(et) * 32'd256, 7'h7F, 7'(1) << (en - 3'd1));
    end

    // Drain: seven more broadcasts then idle.
    bus.src_valid = 7'h00;
    for (int k = 0; k < 7; k++) begin
      et = 3'((k % 7) + 1);
      step();
      chk($sformatf("drain%0d tag", k), 32'(bus.cdb_tag), 32'(et));
    end
    step();
    chk_out("drained", 1'b0, 3'd0, 32'h0, 7'h00, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
